sm_step_ctrl: RTL and testbench

- Run/halt/single-step controller for the CPU core clock.
- Replaces the free-running divided clock with a registered clock-enable pulse (cpuEn), running on the board clock.
- Sequences CPU execution in three ways:
  - continuous run at a programmable divided rate;
  - single-step on button request;
  - automatic halt on an instruction-address breakpoint.
- Sits between the input debouncers and the CPU core, driven by board switches/buttons.

---
 rtl/sm_step_ctrl_pkg.sv | 14 +
 rtl/sm_step_prescaler.sv | 46 ++++
 rtl/sm_step_ctrl.sv | 110 +++++++++++
 tb/tb_sm_step_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/sm_step_ctrl_pkg.sv
// Shared constants for the run/halt/single-step controller.
package sm_step_ctrl_pkg;

  typedef enum logic [1:0] {
    StHalt  = 2'd0,
    StRun   = 2'd1,
    StStep  = 2'd2,
    StBreak = 2'd3
  } state_e;

  localparam int unsigned ShiftDefault = 16;
  localparam int unsigned CntW         = 32;

endpackage

// File: rtl/sm_step_prescaler.sv
// Run-rate prescaler: emits tick once every 2^(SHIFT+devide) cycles while not cleared.
module sm_step_prescaler
  import sm_step_ctrl_pkg::*;
#(
  parameter int unsigned SHIFT = ShiftDefault,
  parameter int unsigned CNT_W = CntW
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic [3:0] devide,
  output logic       tick
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] limit;
  logic [31:0]      expSum;

  // Exponents past the counter width saturate the limit instead of wrapping the shift.
  always_comb begin
    expSum = SHIFT + 32'(devide);
    limit  = '1;
    if (expSum < CNT_W) begin
      limit = (CNT_W'(1) << expSum) - CNT_W'(1);
    end
  end

  // >= rather than == so a lowered rate applies immediately.
  assign tick = ~clear & (cnt_q >= limit);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sm_step_ctrl.sv
// Run/halt/single-step/breakpoint controller producing a registered CPU clock-enable pulse.
// Optional pulse counter on stepCnt is built when SM_STEP_CTRL_CYCLE_CNT_EN is defined.
module sm_step_ctrl
  import sm_step_ctrl_pkg::*;
#(
  parameter int unsigned SHIFT = ShiftDefault,
  parameter int unsigned CNT_W = CntW
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        stepReq,
  input  logic [3:0]  devide,
  input  logic        bpEnable,
  input  logic [31:0] bpAddr,
  input  logic [31:0] pc,
  output logic        cpuEn,
  output logic [1:0]  state,
  output logic [31:0] stepCnt
);

  state_e state_q, state_d;
  logic   cpuEn_q, cpuEn_d;
  logic   stepReq_q;
  logic   stepRise, bpHit, tick, preClear;

  assign stepRise = stepReq & ~stepReq_q;
  assign bpHit    = bpEnable & (pc == bpAddr);
  assign preClear = (state_q != StRun);

  sm_step_prescaler #(
    .SHIFT(SHIFT),
    .CNT_W(CNT_W)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .clear (preClear),
    .devide(devide),
    .tick  (tick)
  );

  always_comb begin
    state_d = state_q;
    cpuEn_d = 1'b0;
    unique case (state_q)
      StHalt: begin
        if (run) begin
          state_d = StRun;
        end else if (stepRise) begin
          state_d = StStep;
          cpuEn_d = 1'b1;
        end
      end
      StRun: begin
        if (!run) begin
          state_d = StHalt;
        end else if (tick && bpHit) begin
          // Halt before the breakpoint instruction executes.
          state_d = StBreak;
        end else if (tick) begin
          cpuEn_d = 1'b1;
        end
      end
      StStep: begin
        state_d = StHalt;
      end
      StBreak: begin
        if (!run) begin
          state_d = StHalt;
        end else if (stepRise) begin
          state_d = StStep;
          cpuEn_d = 1'b1;
        end
      end
      default: state_d = StHalt;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StHalt;
      cpuEn_q   <= 1'b0;
      stepReq_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cpuEn_q   <= cpuEn_d;
      stepReq_q <= stepReq;
    end
  end

  assign cpuEn = cpuEn_q;
  assign state = state_q;

`ifdef SM_STEP_CTRL_CYCLE_CNT_EN
  logic [31:0] stepCnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stepCnt_q <= '0;
    end else if (cpuEn_q) begin
      stepCnt_q <= stepCnt_q + 32'd1;
    end
  end

  assign stepCnt = stepCnt_q;
`else
  assign stepCnt = '0;
`endif

endmodule

// File: tb/tb_sm_step_ctrl.sv
// Scoreboard bench for sm_step_ctrl: expected cpuEn pulse cycles are queued as stimulus is driven.
module tb_sm_step_ctrl;

  localparam logic [1:0] HALT = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] STEP = 2'd2;
  localparam logic [1:0] BRK  = 2'd3;

  logic        clk, rst, run, stepReq, bpEnable, cpuEn, pcClr;
  logic [3:0]  devide;
  logic [31:0] bpAddr, pc, stepCnt;
  logic [1:0]  state;

  int unsigned cyc = 0;
  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned expPulses = 0;
  int unsigned expq[$];
  int unsigned c;

  sm_step_ctrl #(
    .SHIFT(2),
    .CNT_W(32)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .run     (run),
    .stepReq (stepReq),
    .devide  (devide),
    .bpEnable(bpEnable),
    .bpAddr  (bpAddr),
    .pc      (pc),
    .cpuEn   (cpuEn),
    .state   (state),
    .stepCnt (stepCnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Minimal CPU: advance pc by one instruction per enable pulse.
  always @(posedge clk) begin
    if (pcClr) pc <= 32'd0;
    else if (cpuEn) pc <= pc + 32'd4;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic expect_pulse(input int unsigned at);
    expq.push_back(at);
    expPulses++;
  endtask

  task automatic wait_cyc(input int unsigned n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic check_cnt(input string tag);
`ifdef SM_STEP_CTRL_CYCLE_CNT_EN
    check(tag, stepCnt, 32'(expPulses));
`else
    check(tag, stepCnt, 32'd0);
`endif
  endtask

  always @(negedge clk) begin
    if (cpuEn) begin
      if (expq.size() == 0) check("pulse_unexpected", 32'(cyc), 32'hffff_ffff);
      else check("pulse_cycle", 32'(cyc), 32'(expq.pop_front()));
    end
  end

  initial begin
    rst = 1'b1; run = 1'b0; stepReq = 1'b0; devide = 4'd0;
    bpEnable = 1'b0; bpAddr = 32'd0; pcClr = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0; pcClr = 1'b0;
    check("rst_state", {30'd0, state}, {30'd0, HALT});
    check("rst_cpuEn", {31'd0, cpuEn}, 32'd0);
    check("rst_cnt", stepCnt, 32'd0);
    repeat (2) @(negedge clk);

    // Continuous run: first pulse 5 cycles after run, then every 4.
    c = cyc; run = 1'b1;
    expect_pulse(c + 5); expect_pulse(c + 9); expect_pulse(c + 13);
    wait_cyc(c + 14);
    check("run_state", {30'd0, state}, {30'd0, RUN});
    check("run_missing", 32'(expq.size()), 32'd0);
    check_cnt("run_cnt");
    run = 1'b0;
    wait_cyc(c + 17);
    check("halt_state", {30'd0, state}, {30'd0, HALT});

    // Held step button yields exactly one pulse.
    c = cyc; stepReq = 1'b1; expect_pulse(c + 1);
    @(negedge clk); check("step_state", {30'd0, state}, {30'd0, STEP});
    @(negedge clk); check("step_back_halt", {30'd0, state}, {30'd0, HALT});
    repeat (8) @(negedge clk);
    stepReq = 1'b0;
    @(negedge clk);
    check("step_hold_state", {30'd0, state}, {30'd0, HALT});
    check("step_missing", 32'(expq.size()), 32'd0);
    check_cnt("step_cnt");

    // Breakpoint at 0x0C: three pulses, then BREAK without executing 0x0C.
    pcClr = 1'b1; @(negedge clk); pcClr = 1'b0;
    bpEnable = 1'b1; bpAddr = 32'h0000_000C;
    c = cyc; run = 1'b1;
    expect_pulse(c + 5); expect_pulse(c + 9); expect_pulse(c + 13);
    wait_cyc(c + 20);
    check("bp_state", {30'd0, state}, {30'd0, BRK});
    check("bp_missing", 32'(expq.size()), 32'd0);
    c = cyc; stepReq = 1'b1; expect_pulse(c + 1);
    @(negedge clk); check("bp_step_state", {30'd0, state}, {30'd0, STEP});
    @(negedge clk); check("bp_step_halt", {30'd0, state}, {30'd0, HALT});
    run = 1'b0; stepReq = 1'b0;
    @(negedge clk);
    check("bp_after_halt", {30'd0, state}, {30'd0, HALT});
    check("bp_step_missing", 32'(expq.size()), 32'd0);
    check_cnt("bp_cnt");

    // Rate drop mid-count: prescaler at 20 with devide 3, then devide 0.
    bpEnable = 1'b0; devide = 4'd3;
    @(negedge clk);
    c = cyc; run = 1'b1;
    wait_cyc(c + 21);
    devide = 4'd0;
    expect_pulse(c + 22); expect_pulse(c + 26); expect_pulse(c + 30);
    // run drops in the tick cycle: no pulse at c+34.
    wait_cyc(c + 33);
    run = 1'b0;
    check("rate_missing", 32'(expq.size()), 32'd0);
    @(negedge clk);
    check("tick_drop_state", {30'd0, state}, {30'd0, HALT});
    repeat (3) @(negedge clk);
    check("tick_drop_missing", 32'(expq.size()), 32'd0);
    check_cnt("rate_cnt");

    // run=1 beats a simultaneous step edge in HALT.
    c = cyc; run = 1'b1; stepReq = 1'b1; expect_pulse(c + 5);
    @(negedge clk);
    check("run_beats_step", {30'd0, state}, {30'd0, RUN});
    wait_cyc(c + 6);
    run = 1'b0; stepReq = 1'b0;
    repeat (3) @(negedge clk);
    check("prio_missing", 32'(expq.size()), 32'd0);
    check("prio_state", {30'd0, state}, {30'd0, HALT});

    // Reset during STEP drops the pulse immediately.
    c = cyc; stepReq = 1'b1; expect_pulse(c + 1);
    @(negedge clk);
    check("pre_rst_state", {30'd0, state}, {30'd0, STEP});
    #2 rst = 1'b1;
    #1;
    check("rst_step_cpuEn", {31'd0, cpuEn}, 32'd0);
    check("rst_step_state", {30'd0, state}, {30'd0, HALT});
    check("rst_step_cnt", stepCnt, 32'd0);
    expPulses = 0;
    @(negedge clk);
    rst = 1'b0; stepReq = 1'b0;
    repeat (2) @(negedge clk);
    check("end_missing", 32'(expq.size()), 32'd0);
    check("end_state", {30'd0, state}, {30'd0, HALT});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
